// File: rtl/xadac_pkg.sv
// rtl/xadac_pkg.sv - shared XADAC widths, types and arithmetic helpers
package xadac_pkg;

  localparam int SumWidth = 32;
  localparam int IdWidth  = 8;
  localparam int ImmWidth = 8;
  localparam int XLen     = 32;

  typedef logic signed [SumWidth-1:0] SumT;
  typedef logic [IdWidth-1:0]         IdT;

  typedef enum logic [1:0] {
    BCAST = 2'd0,
    ADD   = 2'd1,
    RAMP  = 2'd2,
    RSVD  = 2'd3
  } VbiasModeE;

  // One extra bit catches overflow; the saturated value is {sign, ~sign...}.
  function automatic SumT sat_add_sum(input SumT a, input SumT b);
    logic [SumWidth:0] s;
    s = {a[SumWidth-1], a} + {b[SumWidth-1], b};
    if (s[SumWidth] != s[SumWidth-1]) begin
      sat_add_sum = {s[SumWidth], {(SumWidth-1){~s[SumWidth]}}};
    end else begin
      sat_add_sum = s[SumWidth-1:0];
    end
  endfunction

endpackage

// File: rtl/xadac_if.sv
// rtl/xadac_if.sv - dispatcher-to-vector-unit request/response bus
interface xadac_if #(
  parameter int VecWidth = 8 * xadac_pkg::SumWidth
) ();
  import xadac_pkg::*;

  logic                req_valid;
  logic                req_ready;
  IdT                  req_id;
  logic [ImmWidth-1:0] req_imm;
  logic [XLen-1:0]     req_rs1;
  logic [XLen-1:0]     req_rs2;
  logic [VecWidth-1:0] req_vs1;

  logic                resp_valid;
  logic                resp_ready;
  IdT                  resp_id;
  logic [VecWidth-1:0] resp_vd;
  logic [XLen-1:0]     resp_rd;

  modport mst (
    output req_valid, req_id, req_imm, req_rs1, req_rs2, req_vs1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_vd, resp_rd
  );

  modport slv (
    input  req_valid, req_id, req_imm, req_rs1, req_rs2, req_vs1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_vd, resp_rd
  );

endinterface

// File: rtl/xadac_vbias_lane.sv
// rtl/xadac_vbias_lane.sv - combinational per-lane bias compute
module xadac_vbias_lane #(
  parameter int SumWidth = xadac_pkg::SumWidth,
  parameter int CntW     = 4
) (
  input  logic [CntW-1:0]       i_idx,
  input  logic [CntW-1:0]       i_n,
  input  xadac_pkg::VbiasModeE  i_mode,
  input  logic [SumWidth-1:0]   i_rs1,
  input  logic [SumWidth-1:0]   i_vs1,
  input  logic [SumWidth-1:0]   i_off,
  output logic [SumWidth-1:0]   o_lane
);
  import xadac_pkg::*;

  logic [SumWidth-1:0] w_sat;

  // The package helper is fixed at the package width; other widths use the same rule inline.
  if (SumWidth == xadac_pkg::SumWidth) begin : g_pkg_sat
    assign w_sat = sat_add_sum(i_vs1, i_rs1);
  end else begin : g_gen_sat
    logic [SumWidth:0] w_sum;
    assign w_sum = {i_vs1[SumWidth-1], i_vs1} + {i_rs1[SumWidth-1], i_rs1};
    assign w_sat = (w_sum[SumWidth] != w_sum[SumWidth-1])
                 ? {w_sum[SumWidth], {(SumWidth-1){~w_sum[SumWidth]}}}
                 : w_sum[SumWidth-1:0];
  end

  always_comb begin
    o_lane = '0;
    if (i_idx < i_n) begin
      case (i_mode)
        ADD:     o_lane = w_sat;
        RAMP:    o_lane = i_rs1 + i_off;
        default: o_lane = i_rs1;
      endcase
    end
  end

endmodule

// File: rtl/xadac_vbias_pipe.sv
// rtl/xadac_vbias_pipe.sv - two-stage vector bias unit (broadcast / saturating add / ramp)
module xadac_vbias_pipe #(
  parameter int  NumLanes = 8,
  parameter int  SumWidth = xadac_pkg::SumWidth,
  localparam int CntW     = $clog2(NumLanes + 1),
  localparam int VecWidth = NumLanes * SumWidth
) (
  input logic  clk,
  input logic  rstn,
  xadac_if.slv slv
);
  import xadac_pkg::*;

  logic                w_s1_ready;
  logic                w_s2_ready;
  logic                w_req_fire;
  logic [CntW-1:0]     w_n_raw;
  logic [CntW-1:0]     w_n;
  VbiasModeE           w_mode;
  logic [SumWidth-1:0] w_rs1;
  logic [SumWidth-1:0] w_rs2;
  logic [SumWidth-1:0] w_off [NumLanes];
  logic [VecWidth-1:0] w_vd;

  logic                r_s1_valid;
  logic [CntW-1:0]     r_s1_n;
  VbiasModeE           r_s1_mode;
  logic [SumWidth-1:0] r_s1_rs1;
  logic [VecWidth-1:0] r_s1_vs1;
  IdT                  r_s1_id;
  logic [SumWidth-1:0] r_s1_off [NumLanes];

  logic                r_s2_valid;
  logic [CntW-1:0]     r_s2_n;
  logic [VecWidth-1:0] r_s2_vd;
  IdT                  r_s2_id;

  assign w_s2_ready    = !r_s2_valid || slv.resp_ready;
  assign w_s1_ready    = !r_s1_valid || w_s2_ready;
  assign slv.req_ready = w_s1_ready && rstn;
  assign w_req_fire    = slv.req_valid && slv.req_ready;

  assign w_n_raw = slv.req_imm[CntW-1:0];
  assign w_n     = (w_n_raw > CntW'(NumLanes)) ? CntW'(NumLanes) : w_n_raw;
  assign w_mode  = VbiasModeE'(slv.req_imm[CntW+1:CntW]);
  assign w_rs1   = slv.req_rs1[SumWidth-1:0];
  assign w_rs2   = slv.req_rs2[SumWidth-1:0];

  // Ramp offsets are formed before S1 so S2 only needs one adder per lane.
  for (genvar g = 0; g < NumLanes; g++) begin : g_lane
    assign w_off[g] = SumWidth'(g) * w_rs2;

    xadac_vbias_lane #(
      .SumWidth (SumWidth),
      .CntW     (CntW)
    ) u_lane (
      .i_idx  (CntW'(g)),
      .i_n    (r_s1_n),
      .i_mode (r_s1_mode),
      .i_rs1  (r_s1_rs1),
      .i_vs1  (r_s1_vs1[g*SumWidth +: SumWidth]),
      .i_off  (r_s1_off[g]),
      .o_lane (w_vd[g*SumWidth +: SumWidth])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_n     <= '0;
      r_s1_mode  <= BCAST;
      r_s1_rs1   <= '0;
      r_s1_vs1   <= '0;
      r_s1_id    <= '0;
      for (int i = 0; i < NumLanes; i++) begin
        r_s1_off[i] <= '0;
      end
    end else begin
      if (w_s1_ready) begin
        r_s1_valid <= w_req_fire;
      end
      if (w_req_fire) begin
        r_s1_n    <= w_n;
        r_s1_mode <= w_mode;
        r_s1_rs1  <= w_rs1;
        r_s1_vs1  <= slv.req_vs1;
        r_s1_id   <= slv.req_id;
        for (int i = 0; i < NumLanes; i++) begin
          r_s1_off[i] <= w_off[i];
        end
      end
    end
  end

  // The output register only reloads when it is free, which keeps resp_* stable under stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s2_valid <= 1'b0;
      r_s2_n     <= '0;
      r_s2_vd    <= '0;
      r_s2_id    <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_n  <= r_s1_n;
        r_s2_vd <= w_vd;
        r_s2_id <= r_s1_id;
      end
    end
  end

  assign slv.resp_valid = r_s2_valid;
  assign slv.resp_vd    = r_s2_vd;
  assign slv.resp_id    = r_s2_id;
  assign slv.resp_rd    = {{(XLen-CntW){1'b0}}, r_s2_n};

endmodule
